// File: rtl/mult_seq_ctrl.sv
`timescale 1ns/1ps
// mult_seq_ctrl
// Control unit for a shift-add multiplier datapath (WIDTH x WIDTH -> 2*WIDTH).
// A start request loads the operands and clears the product (LOAD). The unit
// then runs exactly WIDTH shift/accumulate iterations (CALC). A one-cycle done
// pulse follows, during which the product is held (DONE).
//
// Ports:
//   Clock          system clock, rising edge
//   Reset          synchronous, active-high
//   iStart         request a multiply (sampled in IDLE/DONE only)
//   iAbort         cancel a multiply (sampled in LOAD/CALC only)
//   iB_LSB         datapath B-register bit 0, counted as "add performed"
//   oA_Sel         1 = load operand A, 0 = shifted A
//   oB_Sel         1 = load operand B, 0 = shifted B
//   oProd_Sel      1 = clear product, 0 = accumulate
//   oShift_Enable  enables A-left / B-right shifters
//   oReg_Enable    enables all datapath register updates
//   oBusy          high in LOAD and CALC
//   oDone          one-cycle completion pulse
//   oIter          current iteration index, 0 outside CALC
//   oAdds          number of iterations with iB_LSB=1, held after DONE
// All outputs are registered state or decoded from state only, so there is no
// combinational path from any input to any output.
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic             iAbort,
    input  logic             iB_LSB,
    output logic             oA_Sel,
    output logic             oB_Sel,
    output logic             oProd_Sel,
    output logic             oShift_Enable,
    output logic             oReg_Enable,
    output logic             oBusy,
    output logic             oDone,
    output logic [CNT_W-1:0] oIter,
    output logic [CNT_W:0]   oAdds
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCalc,
        StDone
    } state_t;

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_iter;
    logic [CNT_W-1:0] w_iter_next;
    logic [CNT_W:0]   r_adds;
    logic [CNT_W:0]   w_adds_next;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= StIdle;
            r_iter  <= '0;
            r_adds  <= '0;
        end else begin
            r_state <= w_state_next;
            r_iter  <= w_iter_next;
            r_adds  <= w_adds_next;
        end
    end

    // Next-state and counter updates
    always_comb begin
        w_state_next = r_state;
        w_iter_next  = r_iter;
        w_adds_next  = r_adds;
        unique case (r_state)
            StIdle: begin
                if (iStart) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_adds_next  = '0;
                w_state_next = iAbort ? StIdle : StCalc;
            end
            StCalc: begin
                if (iAbort) begin
                    // Abort wins over the exit transition; partial add count is kept.
                    w_state_next = StIdle;
                    w_iter_next  = '0;
                end else begin
                    if (iB_LSB) begin
                        w_adds_next = r_adds + 1'b1;
                    end
                    if (r_iter == LastIter) begin
                        w_iter_next  = '0;
                        w_state_next = StDone;
                    end else begin
                        w_iter_next = r_iter + 1'b1;
                    end
                end
            end
            StDone: begin
                w_state_next = iStart ? StLoad : StIdle;
            end
        endcase
    end

    // Moore output decode
    always_comb begin
        oA_Sel        = 1'b0;
        oB_Sel        = 1'b0;
        oProd_Sel     = 1'b0;
        oShift_Enable = 1'b0;
        oReg_Enable   = 1'b0;
        oBusy         = 1'b0;
        oDone         = 1'b0;
        unique case (r_state)
            StIdle: begin
            end
            StLoad: begin
                oA_Sel      = 1'b1;
                oB_Sel      = 1'b1;
                oProd_Sel   = 1'b1;
                oReg_Enable = 1'b1;
                oBusy       = 1'b1;
            end
            StCalc: begin
                oShift_Enable = 1'b1;
                oReg_Enable   = 1'b1;
                oBusy         = 1'b1;
            end
            StDone: begin
                oDone = 1'b1;
            end
        endcase
    end

    assign oIter = r_iter;
    assign oAdds = r_adds;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
`timescale 1ns/1ps
module tb_mult_seq_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iStart, iAbort, iB_LSB;
    logic       oA_Sel, oB_Sel, oProd_Sel, oShift_Enable, oReg_Enable, oBusy, oDone;
    logic [4:0] oIter;
    logic [5:0] oAdds;

    logic       iStart8, iAbort8, iB_LSB8;
    logic       oA_Sel8, oB_Sel8, oProd_Sel8, oShift_Enable8, oReg_Enable8, oBusy8, oDone8;
    logic [2:0] oIter8;
    logic [3:0] oAdds8;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    mult_seq_ctrl dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iStart        (iStart),
        .iAbort        (iAbort),
        .iB_LSB        (iB_LSB),
        .oA_Sel        (oA_Sel),
        .oB_Sel        (oB_Sel),
        .oProd_Sel     (oProd_Sel),
        .oShift_Enable (oShift_Enable),
        .oReg_Enable   (oReg_Enable),
        .oBusy         (oBusy),
        .oDone         (oDone),
        .oIter         (oIter),
        .oAdds         (oAdds)
    );

    mult_seq_ctrl #(.WIDTH(8)) dut8 (
        .Clock         (Clock),
        .Reset         (Reset),
        .iStart        (iStart8),
        .iAbort        (iAbort8),
        .iB_LSB        (iB_LSB8),
        .oA_Sel        (oA_Sel8),
        .oB_Sel        (oB_Sel8),
        .oProd_Sel     (oProd_Sel8),
        .oShift_Enable (oShift_Enable8),
        .oReg_Enable   (oReg_Enable8),
        .oBusy         (oBusy8),
        .oDone         (oDone8),
        .oIter         (oIter8),
        .oAdds         (oAdds8)
    );

    logic [6:0] outs, outs8;
    assign outs  = {oA_Sel, oB_Sel, oProd_Sel, oShift_Enable, oReg_Enable, oBusy, oDone};
    assign outs8 = {oA_Sel8, oB_Sel8, oProd_Sel8, oShift_Enable8, oReg_Enable8, oBusy8, oDone8};

    // Expected {A,B,Prod,Shift,Reg,Busy,Done} in cycle c after a start sampled at edge 0,
    // where CALC occupies cycles 2..last.
    function automatic logic [6:0] exp_outs(input int c, input int last);
        if (c == 1) return 7'b1110110;
        else if (c >= 2 && c <= last) return 7'b0001110;
        else if (c == last + 1) return 7'b0000001;
        else return 7'b0000000;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; iStart = 1'b0; iAbort = 1'b0; iB_LSB = 1'b0;
        iStart8 = 1'b0; iAbort8 = 1'b0; iB_LSB8 = 1'b0;
        tick();
        tick();
        checks++;
        if (outs !== 7'b0) begin failures++; $display("FAIL reset_outs got %b want 0000000", outs); end
        checks++;
        if (oIter !== 5'd0) begin failures++; $display("FAIL reset_iter got %0d want 0", oIter); end
        checks++;
        if (oAdds !== 6'd0) begin failures++; $display("FAIL reset_adds got %0d want 0", oAdds); end
        checks++;
        if (outs8 !== 7'b0) begin failures++; $display("FAIL reset_outs8 got %b want 0000000", outs8); end
        Reset = 1'b0;
        tick();
    endtask

    // B = 0x00000005: bits 0 and 2 set, so two adds
    task automatic test_single_mult();
        logic [31:0] b_val;
        b_val = 32'h0000_0005;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            checks++;
            if (outs !== exp_outs(c, 33)) begin
                failures++;
                $display("FAIL single_outs c=%0d got %b want %b", c, outs, exp_outs(c, 33));
            end
            if (c >= 2 && c <= 33) begin
                checks++;
                if (oIter !== 5'(c - 2)) begin
                    failures++;
                    $display("FAIL single_iter c=%0d got %0d want %0d", c, oIter, c - 2);
                end
            end
            if (c == 34) begin
                checks++;
                if (oAdds !== 6'd2) begin failures++; $display("FAIL done_adds got %0d want 2", oAdds); end
                checks++;
                if (oIter !== 5'd0) begin failures++; $display("FAIL done_iter got %0d want 0", oIter); end
            end
            iB_LSB = 1'b0;
            if (c >= 2 && c <= 33) iB_LSB = b_val[c - 2];
            tick();
        end
        checks++;
        if (oAdds !== 6'd2) begin failures++; $display("FAIL adds_held got %0d want 2", oAdds); end
    endtask

    task automatic test_back_to_back();
        int n_done, d1, d2;
        n_done = 0; d1 = -1; d2 = -1;
        iStart = 1'b1;
        tick();
        for (int c = 1; c <= 69; c++) begin
            if (oDone === 1'b1) begin
                n_done++;
                if (n_done == 1) d1 = c;
                else if (n_done == 2) d2 = c;
            end
            if (c == 35) begin
                checks++;
                if (outs !== 7'b1110110) begin
                    failures++;
                    $display("FAIL b2b_reload got %b want 1110110", outs);
                end
            end
            if (c == 69) iStart = 1'b0;
            tick();
        end
        checks++;
        if (n_done !== 2) begin failures++; $display("FAIL b2b_count got %0d want 2", n_done); end
        checks++;
        if (d1 !== 34) begin failures++; $display("FAIL b2b_done1 got %0d want 34", d1); end
        checks++;
        if (d2 !== 68) begin failures++; $display("FAIL b2b_done2 got %0d want 68", d2); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int n_done, d1;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            iB_LSB = (c >= 2 && c <= 11);
            if (c == 12) begin
                checks++;
                if (oIter !== 5'd10) begin failures++; $display("FAIL abort_iter_pre got %0d want 10", oIter); end
                iAbort = 1'b1;
            end
            tick();
        end
        iAbort = 1'b0;
        iB_LSB = 1'b0;
        checks++;
        if (outs !== 7'b0) begin failures++; $display("FAIL abort_outs got %b want 0000000", outs); end
        checks++;
        if (oIter !== 5'd0) begin failures++; $display("FAIL abort_iter got %0d want 0", oIter); end
        checks++;
        if (oAdds !== 6'd10) begin failures++; $display("FAIL abort_adds got %0d want 10", oAdds); end
        n_done = 0;
        for (int c = 13; c <= 50; c++) begin
            if (oDone === 1'b1) n_done++;
            tick();
        end
        checks++;
        if (n_done !== 0) begin failures++; $display("FAIL abort_no_done got %0d want 0", n_done); end
        n_done = 0; d1 = -1;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (oDone === 1'b1) begin n_done++; if (d1 < 0) d1 = c; end
            if (c == 2) begin
                checks++;
                if (oAdds !== 6'd0) begin failures++; $display("FAIL restart_adds_clr got %0d want 0", oAdds); end
            end
            tick();
        end
        checks++;
        if (d1 !== 34 || n_done !== 1) begin
            failures++;
            $display("FAIL restart_latency got cycle %0d count %0d want cycle 34 count 1", d1, n_done);
        end
    endtask

    task automatic test_reset_mid();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            iB_LSB = (c >= 2);
            tick();
        end
        checks++;
        if (oIter !== 5'd20) begin failures++; $display("FAIL rst_mid_iter got %0d want 20", oIter); end
        checks++;
        if (oAdds !== 6'd20) begin failures++; $display("FAIL rst_mid_adds got %0d want 20", oAdds); end
        Reset = 1'b1;
        iStart = 1'b1;
        tick();
        Reset = 1'b0;
        iStart = 1'b0;
        iB_LSB = 1'b0;
        checks++;
        if (outs !== 7'b0) begin failures++; $display("FAIL rst_mid_outs got %b want 0000000", outs); end
        checks++;
        if (oIter !== 5'd0 || oAdds !== 6'd0) begin
            failures++;
            $display("FAIL rst_mid_cnt got iter %0d adds %0d want 0 0", oIter, oAdds);
        end
        tick();
        checks++;
        if (outs !== 7'b0) begin failures++; $display("FAIL rst_mid_idle got %b want 0000000", outs); end
    endtask

    task automatic test_start_ignored();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            checks++;
            if (outs !== exp_outs(c, 33)) begin
                failures++;
                $display("FAIL ign_outs c=%0d got %b want %b", c, outs, exp_outs(c, 33));
            end
            iStart = (c == 1 || c == 10 || c == 20);
            tick();
        end
        iStart = 1'b0;
    endtask

    // WIDTH=8: B pattern 8'b1011_0010 has four ones
    task automatic test_width8();
        logic [7:0] b8;
        b8 = 8'b1011_0010;
        iStart8 = 1'b1;
        tick();
        iStart8 = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            checks++;
            if (outs8 !== exp_outs(c, 9)) begin
                failures++;
                $display("FAIL w8_outs c=%0d got %b want %b", c, outs8, exp_outs(c, 9));
            end
            if (c >= 2 && c <= 9) begin
                checks++;
                if (oIter8 !== 3'(c - 2)) begin
                    failures++;
                    $display("FAIL w8_iter c=%0d got %0d want %0d", c, oIter8, c - 2);
                end
            end
            if (c == 10) begin
                checks++;
                if (oAdds8 !== 4'd4) begin failures++; $display("FAIL w8_adds got %0d want 4", oAdds8); end
            end
            iB_LSB8 = 1'b0;
            if (c >= 2 && c <= 9) iB_LSB8 = b8[c - 2];
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_mult();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Control unit for the shift-add multiplier datapath (WIDTH x WIDTH -> 2*WIDTH product).
- Accepts a start request and drives the datapath's operand/product mux selects, shift enable and register enable.
- Sequences exactly WIDTH shift-add iterations, then signals completion with a one-cycle done pulse.
- Sits directly upstream of the datapath; the datapath's B-register LSB is fed back as status.

Parameters:
- WIDTH, 32, operand width; equals the number of iterations per multiply.
- CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high.
- iStart  input  1  request a new multiply; sampled only in IDLE or DONE.
- iAbort  input  1  cancel an in-progress multiply; sampled in LOAD/CALC.
- iB_LSB  input  1  datapath B-register bit 0 (status only).
- oA_Sel  output  1  1 = load operand A into A register; 0 = shifted A.
- oB_Sel  output  1  1 = load operand B into B register; 0 = shifted B.
- oProd_Sel  output  1  1 = clear product register; 0 = accumulate.
- oShift_Enable  output  1  enables the A-left / B-right shifters.
- oReg_Enable  output  1  enables all datapath register updates.
- oBusy  output  1  high in LOAD and CALC.
- oDone  output  1  one-cycle pulse; product register valid and held.
- oIter  output  CNT_W  current iteration index; 0 outside CALC.
- oAdds  output  CNT_W+1  count of iterations with iB_LSB=1 (add performed); held after DONE.

Behaviour:
- Reset (synchronous): state=IDLE; oIter=0; oAdds=0; all outputs 0.
- States: IDLE, LOAD, CALC, DONE. Moore outputs decoded from state.
- IDLE: all outputs 0, registers frozen (oReg_Enable=0). iStart=1 -> LOAD.
- LOAD (exactly 1 cycle): oA_Sel=oB_Sel=oProd_Sel=1, oReg_Enable=1, oBusy=1; oAdds cleared to 0. Next state CALC; iAbort=1 -> IDLE instead.
- CALC (exactly WIDTH cycles): selects=0, oShift_Enable=1, oReg_Enable=1, oBusy=1.
  - Each edge: oIter increments. If iB_LSB=1, oAdds increments.
  - At the edge with oIter==WIDTH-1: oIter <= 0, state -> DONE.
- DONE (1 cycle): oDone=1, oReg_Enable=0 (product held), oBusy=0.
  - iStart=1 -> LOAD (back-to-back permitted); otherwise -> IDLE.
- Latency: iStart sampled at edge k -> LOAD during cycle after k -> CALC covers edges k+2..k+WIDTH+1 -> oDone high in the cycle after edge k+WIDTH+1. Default WIDTH=32 gives oDone 33 cycles after the start edge.
- Start handling:
  - iStart during LOAD/CALC is ignored, not queued.
  - iStart held high continuously issues back-to-back multiplies (IDLE/DONE -> LOAD).
- Abort:
  - iAbort in LOAD/CALC -> IDLE at the next edge; no oDone; oIter=0; oAdds holds its partial value.
  - iAbort has priority over the CALC-exit transition.
  - iAbort in IDLE/DONE is ignored.
- Arithmetic: oIter does not wrap within CALC (exit at WIDTH-1). oAdds saturation is unnecessary; max value is WIDTH, which fits in CNT_W+1 bits.
- Reset mid-operation overrides every other input; next cycle is IDLE.
- No combinational path from any input to any output.

Test Plan:
- Reset, then iStart pulse at edge 0 -> LOAD selects high during cycle 1; oShift_Enable high for exactly 32 cycles; oDone high during cycle 34 only; oBusy high for cycles 1-33.
- Drive iB_LSB from a B=0x00000005 shift model (bits 1,0,1,0...) -> oAdds=2 at DONE; held at 2 in IDLE.
- iStart held high for 70 cycles -> two multiplies; DONE goes straight to LOAD; oDone pulses during cycles 34 and 68.
- iAbort at CALC iteration 10 -> IDLE next edge; oDone never asserted; oIter=0; a new iStart gives full 33-cycle latency.
- Reset asserted at iteration 20 -> next cycle all outputs 0, oAdds=0, state IDLE; iStart during CALC ignored (oDone timing unchanged).
- WIDTH=8 override -> CALC lasts 8 cycles; oDone during cycle 10 after start edge 0; oIter sequence 0..7.
